// File: rtl/i2s_tx_unit_pkg.sv
// ----------------------------------------------------------------------------
// i2s_tx_unit_pkg
// Shared constants, types and helpers for the I2S transmit unit.
//   AUDIO_BITS      : sample width per channel (1..32)
//   I2S_FRAME_BITS  : bits per I2S frame (two slots)
//   I2S_SLOT_BITS   : bits per channel slot
//   FIFO_WIDTH      : width of one stored stereo pair {left, right}
//   i2s_state_t     : transmitter FSM states
//   make_frame()    : builds the 64-bit frame image from a stereo pair
// ----------------------------------------------------------------------------
package i2s_tx_unit_pkg;

    localparam int AUDIO_BITS     = 24;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int FIFO_WIDTH     = 2 * AUDIO_BITS;

    typedef enum logic [1:0] {
        I2S_STOP,
        I2S_RUN,
        I2S_STOPPING
    } i2s_state_t;

    typedef logic [AUDIO_BITS-1:0] sample_t;

    // Each sample is MSB-aligned in its 32-bit slot and padded with zeros, so
    // shifting the frame out MSB first yields left slot then right slot.
    function automatic logic [I2S_FRAME_BITS-1:0] make_frame(input logic [FIFO_WIDTH-1:0] pair);
        logic [I2S_SLOT_BITS-1:0] left_slot;
        logic [I2S_SLOT_BITS-1:0] right_slot;
        left_slot  = I2S_SLOT_BITS'(pair[FIFO_WIDTH-1 -: AUDIO_BITS]) << (I2S_SLOT_BITS - AUDIO_BITS);
        right_slot = I2S_SLOT_BITS'(pair[AUDIO_BITS-1:0]) << (I2S_SLOT_BITS - AUDIO_BITS);
        return {left_slot, right_slot};
    endfunction

endpackage

// File: rtl/i2s_tx_unit_if.sv
// ----------------------------------------------------------------------------
// i2s_tx_unit_if
// Sample-pair handshake between the upstream producer and the I2S unit.
//   tick_in    : audio0_in/audio1_in valid this cycle
//   audio0_in  : left sample, two's complement
//   audio1_in  : right sample, two's complement
//   req_out    : one-cycle request for the next sample pair
// Modports: master = upstream producer, slave = I2S transmit unit.
// ----------------------------------------------------------------------------
interface i2s_tx_unit_if;
    import i2s_tx_unit_pkg::*;

    logic    tick_in;
    sample_t audio0_in;
    sample_t audio1_in;
    logic    req_out;

    modport master (output tick_in, output audio0_in, output audio1_in, input req_out);
    modport slave  (input tick_in, input audio0_in, input audio1_in, output req_out);

endinterface

// File: rtl/i2s_tx_unit_fifo.sv
// ----------------------------------------------------------------------------
// i2s_tx_unit_fifo
// Two-entry FIFO of stereo pairs. Entry 0 is always the head.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (accepted when not full, or when popping)
//   pop         : discard head (ignored when empty)
//   flush       : empty the FIFO; a simultaneous push is discarded
//   push_data   : {left, right} pair to store
//   head_data   : current head pair
//   full, empty : occupancy flags
// ----------------------------------------------------------------------------
module i2s_tx_unit_fifo
    import i2s_tx_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] push_data,
    output logic [FIFO_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    logic [FIFO_WIDTH-1:0] mem_q [2];
    logic [FIFO_WIDTH-1:0] mem_d [2];
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  pop_ok;
    logic                  push_ok;
    logic [1:0]            fill_after_pop;

    // Pop is applied before push, so a full FIFO can accept a push in the
    // same cycle it pops.
    always_comb begin
        mem_d          = mem_q;
        count_d        = count_q;
        pop_ok         = pop && (count_q != 2'd0);
        push_ok        = push && ((count_q != 2'd2) || pop_ok);
        fill_after_pop = count_q - {1'b0, pop_ok};
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                mem_d[0] = mem_q[1];
            end
            if (push_ok) begin
                mem_d[fill_after_pop[0]] = push_data;
            end
            count_d = fill_after_pop + {1'b0, push_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[0];
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/i2s_tx_unit.sv
// ----------------------------------------------------------------------------
// i2s_tx_unit
// Buffers stereo samples in a 2-entry FIFO and serialises them as a Philips
// I2S stream with a 64-bit frame (two 32-bit slots).
//   clk, rst_n    : clock, asynchronous active-low reset
//   play_in       : 1 = stream, 0 = stop after the current frame
//   up (slave)    : tick_in/audio0_in/audio1_in in, req_out pulse out
//   overrun_out   : pulse, a tick was dropped because the FIFO was full
//   underrun_out  : pulse, a frame was loaded with zeros (FIFO empty)
//   sck_out       : I2S bit clock
//   ws_out        : I2S word select (0 = left, 1 = right)
//   sdo_out       : I2S serial data, MSB first
// Parameter HALF_PER: clk cycles per sck half-period (>= 1).
// ----------------------------------------------------------------------------
module i2s_tx_unit
    import i2s_tx_unit_pkg::*;
#(
    parameter int HALF_PER = 2
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            play_in,
    i2s_tx_unit_if.slave    up,
    output logic            overrun_out,
    output logic            underrun_out,
    output logic            sck_out,
    output logic            ws_out,
    output logic            sdo_out
);

    localparam int               DIV_W    = $clog2(2 * HALF_PER);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_PER - 1);
    localparam logic [DIV_W-1:0] SCK_HIGH = DIV_W'(HALF_PER);
    localparam logic [5:0]       LAST_BIT = 6'(I2S_FRAME_BITS - 1);
    localparam logic [5:0]       WS_FIRST = 6'(I2S_SLOT_BITS - 1);
    localparam logic [5:0]       WS_LAST  = 6'(I2S_FRAME_BITS - 2);

    i2s_state_t                state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [5:0]                bit_cnt_q, bit_cnt_d;
    logic [I2S_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                      ws_q, ws_d;
    logic                      sck_q, sck_d;
    logic                      req_q, req_d;
    logic                      underrun_q, underrun_d;
    logic                      overrun_q, overrun_d;

    logic                      bit_end;
    logic                      frame_end;
    logic                      load;
    logic                      stop_now;
    logic                      running_next;
    logic                      fifo_pop;
    logic                      fifo_flush;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_WIDTH-1:0]     fifo_head;

    i2s_tx_unit_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (up.tick_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data ({up.audio0_in, up.audio1_in}),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The next-state logic decides at each clock whether a new frame is
    // loaded or the stream stops. A frame ending in RUN with play_in low
    // stops directly, since the frame that was current has just completed.
    // All I2S outputs are computed from the next position and registered so
    // ws/sdo move exactly on the edge where sck falls.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        req_d      = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;
        stop_now   = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        bit_end    = (div_q == DIV_LAST);
        frame_end  = bit_end && (bit_cnt_q == LAST_BIT);

        unique case (state_q)
            I2S_STOP: begin
                if (play_in) begin
                    state_d = I2S_RUN;
                    load    = 1'b1;
                end
            end
            I2S_RUN: begin
                if (frame_end) begin
                    if (play_in) begin
                        load = 1'b1;
                    end else begin
                        state_d  = I2S_STOP;
                        stop_now = 1'b1;
                    end
                end else if (!play_in) begin
                    state_d = I2S_STOPPING;
                end
            end
            I2S_STOPPING: begin
                if (frame_end) begin
                    if (play_in) begin
                        state_d = I2S_RUN;
                        load    = 1'b1;
                    end else begin
                        state_d  = I2S_STOP;
                        stop_now = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = I2S_STOP;
                stop_now = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop   = 1'b1;
            req_d      = 1'b1;
            underrun_d = fifo_empty;
            shreg_d    = fifo_empty ? '0 : make_frame(fifo_head);
            div_d      = '0;
            bit_cnt_d  = '0;
        end else if (stop_now) begin
            fifo_flush = 1'b1;
            shreg_d    = '0;
            div_d      = '0;
            bit_cnt_d  = '0;
        end else if (state_q != I2S_STOP) begin
            if (bit_end) begin
                div_d     = '0;
                bit_cnt_d = bit_cnt_q + 6'd1;
                shreg_d   = {shreg_q[I2S_FRAME_BITS-2:0], 1'b0};
            end else begin
                div_d     = div_q + 1'b1;
            end
        end

        running_next = (state_d != I2S_STOP);
        ws_d         = running_next && (bit_cnt_d >= WS_FIRST) && (bit_cnt_d <= WS_LAST);
        sck_d        = running_next && (div_d >= SCK_HIGH);
        overrun_d    = up.tick_in && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= I2S_STOP;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ws_q       <= 1'b0;
            sck_q      <= 1'b0;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ws_q       <= ws_d;
            sck_q      <= sck_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign up.req_out   = req_q;
    assign overrun_out  = overrun_q;
    assign underrun_out = underrun_q;
    assign sck_out      = sck_q;
    assign ws_out       = ws_q;
    assign sdo_out      = shreg_q[I2S_FRAME_BITS-1];

endmodule

// File: tb/tb_i2s_tx_unit.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx_unit
// Self-checking bench for i2s_tx_unit. A frame-level reference model (sample
// queue, frame start time, bit position derived arithmetically) predicts all
// outputs every cycle; directed checks cover the entry, streaming, underrun,
// overrun, stop and asynchronous reset scenarios.
// ----------------------------------------------------------------------------
module tb_i2s_tx_unit;
    import i2s_tx_unit_pkg::*;

    localparam int HALF_PER  = 2;
    localparam int BIT_CLK   = 2 * HALF_PER;
    localparam int FRAME_CLK = I2S_FRAME_BITS * BIT_CLK;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic play_in = 1'b0;
    logic overrun_out, underrun_out, sck_out, ws_out, sdo_out;

    i2s_tx_unit_if up_if ();

    i2s_tx_unit #(.HALF_PER(HALF_PER)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_in      (play_in),
        .up           (up_if.slave),
        .overrun_out  (overrun_out),
        .underrun_out (underrun_out),
        .sck_out      (sck_out),
        .ws_out       (ws_out),
        .sdo_out      (sdo_out)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cycle = 0;
    string phase = "init";

    // Reference model state: playing flag, time within the current frame,
    // the pair being played and the queue of waiting pairs.
    logic                  m_run = 1'b0;
    int                    m_t   = 0;
    logic [FIFO_WIDTH-1:0] m_frame = '0;
    logic [FIFO_WIDTH-1:0] m_q [$];
    logic                  m_req = 1'b0;
    logic                  m_ovr = 1'b0;
    logic                  m_und = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic modelReset();
        m_run = 1'b0;
        m_t   = 0;
        m_q.delete();
        m_req = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
    endtask

    task automatic modelEdge(input logic play, input logic tick, input sample_t l, input sample_t r);
        logic load;
        logic stop;
        load  = 1'b0;
        stop  = 1'b0;
        m_req = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        if (!m_run) begin
            if (play) load = 1'b1;
        end else if (m_t == FRAME_CLK - 1) begin
            if (play) load = 1'b1;
            else      stop = 1'b1;
        end else begin
            m_t++;
        end
        if (load) begin
            m_run = 1'b1;
            m_t   = 0;
            m_req = 1'b1;
            if (m_q.size() > 0) begin
                m_frame = m_q.pop_front();
            end else begin
                m_frame = '0;
                m_und   = 1'b1;
            end
        end
        if (tick) begin
            if (m_q.size() < 2) m_q.push_back({l, r});
            else                m_ovr = 1'b1;
        end
        if (stop) begin
            m_run = 1'b0;
            m_t   = 0;
            m_q.delete();
        end
    endtask

    function automatic logic expSdo(input int b);
        if (b < AUDIO_BITS)
            return m_frame[AUDIO_BITS + AUDIO_BITS - 1 - b];
        if (b >= I2S_SLOT_BITS && b < I2S_SLOT_BITS + AUDIO_BITS)
            return m_frame[AUDIO_BITS - 1 - (b - I2S_SLOT_BITS)];
        return 1'b0;
    endfunction

    // Packed as {sck, ws, sdo, req, overrun, underrun}.
    function automatic logic [5:0] expOutputs();
        int  b;
        logic sck, ws, sdo;
        sck = 1'b0;
        ws  = 1'b0;
        sdo = 1'b0;
        if (m_run) begin
            b   = m_t / BIT_CLK;
            sck = (m_t % BIT_CLK) >= HALF_PER;
            ws  = (b >= 31) && (b <= 62);
            sdo = expSdo(b);
        end
        return {sck, ws, sdo, m_req, m_ovr, m_und};
    endfunction

    function automatic logic [5:0] dutOutputs();
        return {sck_out, ws_out, sdo_out, up_if.req_out, overrun_out, underrun_out};
    endfunction

    task automatic applyStimulus(input logic play, input logic tick, input sample_t l, input sample_t r);
        play_in         = play;
        up_if.tick_in   = tick;
        up_if.audio0_in = l;
        up_if.audio1_in = r;
        @(posedge clk);
        cycle++;
        if (rst_n) modelEdge(play, tick, l, r);
        else       modelReset();
        #1;
        checkOutput(phase, 64'(dutOutputs()), 64'(expOutputs()));
    endtask

    // Called at posedge+1; asserts reset between edges and checks that the
    // outputs clear without waiting for a clock.
    task automatic doAsyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset", 64'(dutOutputs()), 64'd0);
        @(posedge clk);
        #1;
        cycle++;
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] cap;
        logic [63:0] wcap;
        int          cd;
        int          last_req;
        int          und_cnt;
        int          ovr_cnt;
        logic        rp;

        up_if.tick_in   = 1'b0;
        up_if.audio0_in = '0;
        up_if.audio1_in = '0;
        cap  = '0;
        wcap = '0;

        // Reset and idle with play low
        phase = "reset";
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 24'h123456, 24'h654321);
        rst_n = 1'b1;
        phase = "idle";
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0, '0);

        // Single known pair, checked against the literal bit pattern
        phase = "first_frame";
        applyStimulus(1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A);
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("entry_req", 64'(up_if.req_out), 64'd1);
        checkOutput("entry_no_underrun", 64'(underrun_out), 64'd0);
        for (int i = 0; i < FRAME_CLK; i++) begin
            if (i % BIT_CLK == HALF_PER) begin
                cap[63 - i / BIT_CLK]  = sdo_out;
                wcap[63 - i / BIT_CLK] = ws_out;
            end
            applyStimulus(1'b1, 1'b0, '0, '0);
        end
        checkOutput("frame_bits", cap, 64'hA5A5A500_5A5A5A00);
        checkOutput("ws_bits", wcap, 64'h00000001_FFFFFFFE);

        // Streaming: answer every request 10 clocks later
        phase    = "stream";
        cd       = 10;
        last_req = -1;
        und_cnt  = 0;
        ovr_cnt  = 0;
        for (int i = 0; i < 8 * FRAME_CLK; i++) begin
            applyStimulus(1'b1, cd == 1, sample_t'($urandom), sample_t'($urandom));
            if (cd > 0) cd--;
            if (m_req) cd = 10;
            if (underrun_out) und_cnt++;
            if (overrun_out)  ovr_cnt++;
            if (up_if.req_out) begin
                if (last_req >= 0) checkOutput("spacing", 64'(cycle - last_req), 64'(FRAME_CLK));
                last_req = cycle;
            end
        end
        checkOutput("stream_underruns", 64'(und_cnt), 64'd0);
        checkOutput("stream_overruns", 64'(ovr_cnt), 64'd0);

        // Starve the FIFO while running
        phase   = "underrun";
        und_cnt = 0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0);
            if (underrun_out) und_cnt++;
        end
        checkOutput("underrun_seen", 64'(und_cnt >= 1), 64'd1);

        // Stop, then overrun in STOP, then tick and pop on the same edge
        phase = "overrun";
        for (int i = 0; i < 2 * FRAME_CLK && m_run; i++) applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 24'h111111, 24'h222222);
        checkOutput("overrun_first", 64'(overrun_out), 64'd0);
        applyStimulus(1'b0, 1'b1, 24'h333333, 24'h444444);
        checkOutput("overrun_second", 64'(overrun_out), 64'd0);
        applyStimulus(1'b0, 1'b1, 24'h555555, 24'h666666);
        checkOutput("overrun_third", 64'(overrun_out), 64'd1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("overrun_pulse_end", 64'(overrun_out), 64'd0);
        applyStimulus(1'b1, 1'b1, 24'h777777, 24'h888888);
        checkOutput("tick_pop_no_overrun", 64'(overrun_out), 64'd0);
        checkOutput("entry_req2", 64'(up_if.req_out), 64'd1);
        checkOutput("entry2_no_underrun", 64'(underrun_out), 64'd0);

        // Drop play at b=10: frame completes, FIFO is flushed
        phase = "stop_mid";
        for (int i = 0; i < FRAME_CLK && m_t != 10 * BIT_CLK; i++) applyStimulus(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < FRAME_CLK + 4 && m_run; i++) applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("flushed_underrun", 64'(underrun_out), 64'd1);
        for (int i = 0; i < FRAME_CLK && m_t != 40 * BIT_CLK; i++) applyStimulus(1'b1, 1'b0, '0, '0);
        doAsyncReset();

        // Random traffic with occasional play toggles and resets
        phase = "random";
        rp    = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(399) == 0) rp = ~rp;
            if ($urandom_range(2999) == 0) doAsyncReset();
            applyStimulus(rp, $urandom_range(59) == 0, sample_t'($urandom), sample_t'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
